// File: rtl/counter_seq_pkg.sv
// Shared types for the counter sequencer: FSM states, run modes and the
// command-mode decoder.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'b00,
    MODE_RELOAD  = 2'b01,
    MODE_BOUNCE  = 2'b10
  } mode_t;

  // The reserved encoding 2'b11 runs as a one-shot.
  function automatic mode_t decode_mode(input logic [1:0] raw);
    case (raw)
      2'b01:   return MODE_RELOAD;
      2'b10:   return MODE_BOUNCE;
      default: return MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/counter_updown_load.sv
// WIDTH-bit loadable up/down counter; load has priority over stepping and
// all arithmetic wraps modulo 2^WIDTH.
module counter_updown_load #(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             dir,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven run controller for the up/down counter: accepts one run
// command in IDLE, steps the counter in RUN and pulses done on completion.
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_start,
  input  logic [WIDTH-1:0] cmd_limit,
  input  logic             cmd_dir,
  input  logic [1:0]       cmd_mode,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] count,
  output logic             dir_out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic             dir_q, dir_d;
  logic             orig_dir_q, orig_dir_d;

  logic             cnt_load;
  logic [WIDTH-1:0] cnt_val;
  logic             cnt_en;
  logic             cnt_dir;
  logic             at_limit;
  logic             at_start;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign dir_out   = dir_q;

  assign at_limit = (count == limit_q);
  // The start endpoint only turns a bounce around on the way back, so the
  // very first RUN cycle at start does not reverse immediately.
  assign at_start = (count == start_q) && (dir_q != orig_dir_q);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would infer a latch.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    start_d    = start_q;
    limit_d    = limit_q;
    dir_d      = dir_q;
    orig_dir_d = orig_dir_q;
    cnt_load   = 1'b0;
    cnt_val    = start_q;
    cnt_en     = 1'b0;
    cnt_dir    = dir_q;
    tc         = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          start_d    = cmd_start;
          limit_d    = cmd_limit;
          mode_d     = decode_mode(cmd_mode);
          dir_d      = cmd_dir;
          orig_dir_d = cmd_dir;
          cnt_load   = 1'b1;
          cnt_val    = cmd_start;
          state_d    = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!pause) begin
          tc = at_limit || ((mode_q == MODE_BOUNCE) && at_start);
          if (!tc) begin
            cnt_en = 1'b1;
          end else begin
            case (mode_q)
              MODE_RELOAD: cnt_load = 1'b1;
              MODE_BOUNCE: begin
                dir_d   = !dir_q;
                cnt_dir = !dir_q;
                // With start == limit there is nowhere to go: hold the count.
                cnt_en  = (start_q != limit_q);
              end
              default:     state_d = DONE;
            endcase
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      mode_q     <= MODE_ONESHOT;
      start_q    <= '0;
      limit_q    <= '0;
      dir_q      <= 1'b1;
      orig_dir_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      start_q    <= start_d;
      limit_q    <= limit_d;
      dir_q      <= dir_d;
      orig_dir_q <= orig_dir_d;
    end
  end

  counter_updown_load #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .load    (cnt_load),
    .load_val(cnt_val),
    .en      (cnt_en),
    .dir     (cnt_dir),
    .count   (count)
  );

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: a table of per-cycle vectors
// with expected outputs, plus a hand-written wrap-around one-shot run.
module tb_counter_sequencer;

  localparam int W = 3;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [W-1:0] cmd_start = '0;
  logic [W-1:0] cmd_limit = '0;
  logic         cmd_dir = 1'b1;
  logic [1:0]   cmd_mode = 2'b00;
  logic         pause = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] count;
  logic         dir_out;
  logic         busy;
  logic         tc;
  logic         done;

  counter_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_start(cmd_start),
    .cmd_limit(cmd_limit),
    .cmd_dir  (cmd_dir),
    .cmd_mode (cmd_mode),
    .pause    (pause),
    .abort    (abort),
    .count    (count),
    .dir_out  (dir_out),
    .busy     (busy),
    .tc       (tc),
    .done     (done)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] count;
    logic       dir;
    logic       busy;
    logic       tc;
    logic       done;
    logic       ready;
  } out_t;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [2:0] start;
    logic [2:0] limit;
    logic       dir;
    logic [1:0] mode;
    logic       pause;
    logic       abort;
    out_t       exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Inputs for one cycle, then the outputs expected during that cycle.
  function automatic vec_t mk(input int rst, vld, s, l, d, m, p, a,
                              input int c, od, b, t, dn, r);
    vec_t v;
    v.rst = 1'(rst);  v.valid = 1'(vld);
    v.start = 3'(s);  v.limit = 3'(l);
    v.dir = 1'(d);    v.mode = 2'(m);
    v.pause = 1'(p);  v.abort = 1'(a);
    v.exp = '{count: 3'(c), dir: 1'(od), busy: 1'(b), tc: 1'(t),
              done: 1'(dn), ready: 1'(r)};
    return v;
  endfunction

  function automatic out_t sample();
    return '{count: count, dir: dir_out, busy: busy, tc: tc, done: done,
             ready: cmd_ready};
  endfunction

  task automatic check(input string name, input out_t act);
    out_t exp;
    n_vec++;
    if (sb.size() == 0) begin
      n_err++;
      $display("FAIL %s: scoreboard empty, nothing to compare against", name);
    end else begin
      exp = sb.pop_front();
      if (act !== exp) begin
        n_err++;
        $display("FAIL %s: got count=%0d dir=%b busy=%b tc=%b done=%b ready=%b, want count=%0d dir=%b busy=%b tc=%b done=%b ready=%b",
                 name, act.count, act.dir, act.busy, act.tc, act.done, act.ready,
                 exp.count, exp.dir, exp.busy, exp.tc, exp.done, exp.ready);
      end
    end
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clock);
    reset     = v.rst;
    cmd_valid = v.valid;
    cmd_start = v.start;
    cmd_limit = v.limit;
    cmd_dir   = v.dir;
    cmd_mode  = v.mode;
    pause     = v.pause;
    abort     = v.abort;
    sb.push_back(v.exp);
    #2;
    check(name, sample());
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //               rst v  s  l  d  m  p  a   cnt dir bsy tc dn rdy
    // reset state
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1));
    // ONESHOT up 2 -> 5
    vecs.push_back(mk(0, 1, 2, 5, 1, 0, 0, 0,   0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1));
    // ONESHOT down 1 -> 6 through wrap
    vecs.push_back(mk(0, 1, 1, 6, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   7, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   6, 0, 0, 0, 0, 1));
    // RELOAD up 0 -> 2, abort at count 1
    vecs.push_back(mk(0, 1, 0, 2, 1, 1, 0, 0,   6, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0, 1));
    // BOUNCE up 1 <-> 3, abort on the way down
    vecs.push_back(mk(0, 1, 1, 3, 1, 2, 0, 0,   1, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 0, 0, 0, 0, 1));
    // ONESHOT up 2 -> 5 with pauses at 4 and at the limit
    vecs.push_back(mk(0, 1, 2, 5, 1, 0, 0, 0,   2, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   5, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,   5, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 1, 0, 0, 0, 1));
    // cmd_valid held during RUN and DONE is ignored
    vecs.push_back(mk(0, 1, 0, 2, 1, 0, 0, 0,   5, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 7, 7, 0, 1, 0, 0,   0, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 7, 0, 1, 0, 0,   1, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 7, 7, 0, 1, 0, 0,   2, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 1, 7, 7, 0, 1, 0, 0,   2, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0, 1));
    // start == limit: ONESHOT, BOUNCE, RELOAD
    vecs.push_back(mk(0, 1, 4, 4, 1, 0, 0, 0,   2, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 4, 4, 1, 2, 0, 0,   4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   4, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 1, 3, 3, 0, 1, 0, 0,   4, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1,   3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   3, 0, 0, 0, 0, 1));
    // reserved mode 2'b11 runs as ONESHOT
    vecs.push_back(mk(0, 1, 6, 7, 1, 3, 0, 0,   3, 0, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   6, 1, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   7, 1, 1, 1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   7, 1, 0, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0, 1));
    // reset mid-RUN at count 3 (counting down)
    vecs.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0,   7, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   5, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   4, 0, 1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0,   3, 0, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1));

    reset = 1'b1;
    repeat (2) @(posedge clock);

    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end

    // ONESHOT up 6 -> 5: must wrap through 7 and 0 before terminating.
    begin
      logic [2:0] mc;
      int         run_cycles;
      mc = 3'd6;
      run_cycles = 0;
      @(negedge clock);
      cmd_valid = 1'b1;
      cmd_start = 3'd6;
      cmd_limit = 3'd5;
      cmd_dir   = 1'b1;
      cmd_mode  = 2'b00;
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int k = 0; k < 20; k++) begin
        #2;
        if (done) break;
        sb.push_back('{count: mc, dir: 1'b1, busy: 1'b1, tc: (mc == 3'd5),
                       done: 1'b0, ready: 1'b0});
        check($sformatf("wrap_run%0d", k), sample());
        mc = mc + 3'd1;
        run_cycles++;
        @(negedge clock);
      end
      sb.push_back('{count: 3'd5, dir: 1'b1, busy: 1'b0, tc: 1'b0,
                     done: 1'b1, ready: 1'b0});
      check("wrap_done", sample());
      n_vec++;
      if (run_cycles != 8) begin
        n_err++;
        $display("FAIL wrap_len: RUN lasted %0d cycles, want 8", run_cycles);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
Command-driven controller for the team's N-bit up/down counter datapath. Accepts a run command (start value, limit, direction, mode) over a valid/ready handshake and loads and steps the counter. It flags terminal count and reports completion. Sits between a CPU/register-file front end and the counter; replaces the compile-time up/down selection with run-time control.

Parameters:
WIDTH, 3, counter width in bits; all count arithmetic is modulo 2^WIDTH

Ports:
clock      in   1      rising-edge clock
reset      in   1      synchronous, active-high reset
cmd_valid  in   1      command present
cmd_ready  out  1      command can be accepted; high only in IDLE
cmd_start  in   WIDTH  initial count value
cmd_limit  in   WIDTH  terminal count value
cmd_dir    in   1      1 = count up, 0 = count down
cmd_mode   in   2      00 ONESHOT, 01 RELOAD, 10 BOUNCE, 11 reserved (treated as ONESHOT)
pause      in   1      hold count while running
abort      in   1      terminate current run
count      out  WIDTH  current counter value
dir_out    out  1      current direction
busy       out  1      high in RUN
tc         out  1      terminal-count flag (combinational from state/count/pause)
done       out  1      one-cycle completion pulse

Behaviour:
- Reset (sync, active-high): state=IDLE, count=0, dir_out=1, busy=0, tc=0, done=0, cmd_ready=1. Reset overrides all other inputs and clears any run in progress.
- States: IDLE, RUN, DONE. cmd_ready=(IDLE), busy=(RUN), done=(DONE).
- IDLE: at an edge with cmd_valid&&cmd_ready, latch start/limit/mode. Set count<=cmd_start, dir_out<=cmd_dir, state<=RUN. count holds otherwise.
- Latency: command accepted at edge k gives count==start after k; first step at edge k+1.
- RUN, pause=0: tc = (count==limit), or in BOUNCE (count==limit)||(count==start). At each edge:
  - tc=0: count<=count+1 (dir_out=1) or count-1 (dir_out=0), wrapping modulo 2^WIDTH.
  - tc=1, ONESHOT: count holds, state<=DONE.
  - tc=1, RELOAD: count<=start, stay RUN.
  - tc=1, BOUNCE: dir_out toggles; count steps one in the new direction, stay RUN.
- RUN, pause=1: count, dir_out and state hold; tc forced 0.
- DONE: lasts exactly one cycle, then IDLE; count retains limit.
- abort: in RUN or DONE, next state IDLE. count and dir_out hold; tc forced 0; no done pulse. Priority: reset > abort > pause > tc/step. Ignored in IDLE.
- cmd_valid outside IDLE is ignored; it does not queue.
- start==limit: ONESHOT gives tc in the first RUN cycle, then DONE. RELOAD and BOUNCE hold count with tc=1 every cycle (BOUNCE toggles dir_out each cycle).
- Unreachable-looking limits are reached via wrap-around; no error is flagged.

Decomposition:
- Package counter_seq_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - mode_t enum with MODE_ONESHOT=2'b00, MODE_RELOAD=2'b01, MODE_BOUNCE=2'b10
- Sub-module counter_updown_load: WIDTH-bit register with load/load_val, en and dir inputs, plus synchronous active-high reset to 0.
- counter_sequencer holds the FSM, command registers and tc logic, and instantiates one counter_updown_load.

Test Plan:
- WIDTH=3, ONESHOT, up, start=2, limit=5 -> count 2,3,4,5 on consecutive cycles; tc high only at 5; done pulses next cycle; cmd_ready returns to 1 after done.
- ONESHOT, down, start=1, limit=6 -> count 1,0,7,6 (wrap); tc at 6; done once.
- RELOAD, up, start=0, limit=2 -> 0,1,2,0,1,2,...; tc every third cycle; abort at count=1 -> IDLE next cycle, count stays 1, no done.
- BOUNCE, up, start=1, limit=3 -> 1,2,3,2,1,2,3; tc at each 3 and each later 1; dir_out toggles at each endpoint.
- Pause for 3 cycles at count=4, then again while count==limit=5 -> count holds; tc=0 during pause; run resumes and completes normally.
- Reset asserted mid-RUN at count=3 -> next cycle count=0, IDLE, cmd_ready=1. Separately, cmd_valid during RUN is ignored, and start==limit=4 ONESHOT gives tc on the first cycle, then done.
